// File: rtl/x2050_wb_pkg.sv
// Shared definitions for the 2050 storage-path Wishbone initiator and its responders.
package x2050_wb_pkg;

  localparam int unsigned WbAw = 16;
  localparam int unsigned WbDw = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wbtimer50.sv
// Clearable saturating idle counter; expired fires on the edge the count would reach TIMEOUT.
module wbtimer50 #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntMax  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_run && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign o_expired = i_run && !i_clear && (cnt_q == CntLast);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wbmaster50.sv
// Pipelined Wishbone initiator: single-word masked write or 1..MAXLEN word burst read,
// with in-order read return and an idle timeout abort.
module wbmaster50
  import x2050_wb_pkg::*;
#(
  parameter int unsigned AW      = WbAw,
  parameter int unsigned DW      = WbDw,
  parameter int unsigned MAXLEN  = 8,
  parameter int unsigned TIMEOUT = 64,
  localparam int unsigned LW     = $clog2(MAXLEN),
  localparam int unsigned SW     = DW / 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_cmd_stb,
  input  logic          i_cmd_we,
  input  logic [AW-1:0] i_cmd_addr,
  input  logic [LW-1:0] i_cmd_len,
  input  logic [DW-1:0] i_cmd_data,
  input  logic [SW-1:0] i_cmd_sel,
  output logic          o_busy,
  output logic          o_rd_valid,
  output logic [DW-1:0] o_rd_data,
  output logic [LW-1:0] o_rd_index,
  output logic          o_done,
  output logic          o_err,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  output logic [SW-1:0] o_wb_sel,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic [DW-1:0] i_wb_data
);

  wb_state_e     state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW:0]   issue_q, issue_d;
  logic [LW:0]   ack_q, ack_d;
  logic          rd_valid_q, rd_valid_d;
  logic [DW-1:0] rd_data_q, rd_data_d;
  logic [LW-1:0] rd_index_q, rd_index_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic cyc, stb, accept, ack, expired;

  assign cyc    = (state_q != StIdle);
  assign stb    = (state_q == StIssue);
  assign accept = stb && !i_wb_stall;
  assign ack    = cyc && i_wb_ack;

  // Any bus progress restarts the idle window; it also sits cleared between commands.
  wbtimer50 #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   (accept || ack || !cyc),
    .i_run     (cyc),
    .o_expired (expired)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    addr_d     = addr_q;
    data_d     = data_q;
    sel_d      = sel_q;
    len_d      = len_q;
    issue_d    = issue_q;
    ack_d      = ack_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    rd_index_d = rd_index_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_cmd_stb) begin
          state_d = StIssue;
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          data_d  = i_cmd_data;
          sel_d   = i_cmd_we ? i_cmd_sel : '1;
          len_d   = i_cmd_we ? '0 : i_cmd_len;
          issue_d = '0;
          ack_d   = '0;
        end
      end
      default: begin
        if (accept) begin
          issue_d = issue_q + (LW+1)'(1);
          addr_d  = addr_q + AW'(1);
          if (issue_q == {1'b0, len_q}) begin
            state_d = StWait;
          end
        end
        if (ack) begin
          ack_d = ack_q + (LW+1)'(1);
          if (!we_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = i_wb_data;
            rd_index_d = ack_q[LW-1:0];
          end
          if (ack_q == {1'b0, len_q}) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end else if (expired) begin
          state_d = StIdle;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      sel_q      <= '0;
      len_q      <= '0;
      issue_q    <= '0;
      ack_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_index_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      len_q      <= len_d;
      issue_q    <= issue_d;
      ack_q      <= ack_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_index_q <= rd_index_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign o_busy     = cyc;
  assign o_wb_cyc   = cyc;
  assign o_wb_stb   = stb;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = data_q;
  assign o_wb_sel   = sel_q;
  assign o_rd_valid = rd_valid_q;
  assign o_rd_data  = rd_data_q;
  assign o_rd_index = rd_index_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule
